// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: latches two operands on start and resolves one bit per clock,
// LSB first, through a single carry/borrow flip-flop; result/cout update only on the final bit.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [WIDTH-2:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sel_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;

  logic             accept;
  logic             last_bit;
  logic             a_bit, b_bit, x_bit, s_bit;
  logic             c_add, c_sub, c_next;
  logic [WIDTH-1:0] acc_full;

  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

  // One full adder / full subtractor cell, shared across all bit positions.
  assign a_bit  = a_sh_reg[0];
  assign b_bit  = b_sh_reg[0];
  assign x_bit  = a_bit ^ b_bit;
  assign s_bit  = x_bit ^ carry_reg;
  assign c_add  = (a_bit & b_bit) | (carry_reg & x_bit);
  assign c_sub  = (~a_bit & b_bit) | (carry_reg & ~x_bit);
  assign c_next = sel_reg ? c_sub : c_add;

  // New bit enters at the MSB; after WIDTH bits the LSB-first stream lines up.
  assign acc_full = {s_bit, acc_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sel_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      sel_reg   <= sel;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      carry_reg <= c_next;
      cnt_reg   <= cnt_reg + CW'(1);
      acc_reg   <= acc_full[WIDTH-1:1];
      if (last_bit) begin
        result_reg <= acc_full;
        cout_reg   <= c_next;
      end
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8) plus an exhaustive sweep of a WIDTH=4 instance;
// expected results are queued at launch and popped when done is observed.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, sel8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] result8;
  logic       start4, sel4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] result4;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_r = 8'h00;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sel(sel4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic s, input int a, input int b, input logic ci);
    exp_t e;
    int   mask;
    int   t;
    mask = (1 << w) - 1;
    if (!s) begin
      t   = a + b + int'(ci);
      e.r = 8'(t & mask);
      e.c = 1'((t >> w) & 1);
    end else begin
      t   = a - b - int'(ci);
      e.r = 8'(t & mask);
      e.c = (a < b + int'(ci));
    end
    return e;
  endfunction

  // Called just after a falling edge; returns at the falling edge after the start edge.
  task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ci);
    start8 = 1'b1; sel8 = s; a8 = a; b8 = b; cin8 = ci;
    sb_q.push_back(model(8, s, int'(a), int'(b), ci));
    @(posedge clk); @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sel8 = ~s; cin8 = ~ci;
  endtask

  task automatic wait_done8(input bit noise, output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (done8) begin
        edges  = i;
        start8 = 1'b0;
        return;
      end
      if (noise) begin
        check("busy_during_noise", 32'(busy8), 32'd1);
        start8 = (i == 2) || (i == 5);
        a8 = 8'($urandom); b8 = 8'($urandom); sel8 = ~sel8; cin8 = ~cin8;
      end
    end
    start8 = 1'b0;
    check("done8_timeout", 32'(edges), 32'd8);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input bit noise, input bit tail);
    int   edges;
    exp_t e;
    launch8(s, a, b, ci);
    check("busy_run", 32'(busy8), 32'd1);
    check("result_hold_run", 32'(result8), 32'(last_r));
    wait_done8(noise, edges);
    check("latency8", 32'(edges), 32'd8);
    check("sb_pending", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("result8", 32'(result8), 32'(e.r));
      check("cout8", 32'(cout8), 32'(e.c));
      last_r = e.r;
    end
    $display("op8 sel=%0d a=%02h b=%02h cin=%0d -> result=%02h cout=%0d edges=%0d",
             s, a, b, ci, result8, cout8, edges);
    if (tail) begin
      @(posedge clk); @(negedge clk);
      check("done_width", 32'(done8), 32'd0);
      check("busy_idle", 32'(busy8), 32'd0);
      check("result_hold_idle", 32'(result8), 32'(last_r));
    end
  endtask

  initial begin
    int   seen;
    int   edges;
    exp_t e;

    rst_n = 1'b0;
    start8 = 1'b0; sel8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; sel4 = 1'b0; cin4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    #12;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_result8", 32'(result8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_result4", 32'(result4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(1'b0, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b1);
    op8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    op8(1'b1, 8'h10, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(1'b1, 8'h05, 8'h05, 1'b1, 1'b0, 1'b1);

    // Ignored starts mid-run, then a back-to-back start in the done cycle.
    op8(1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    op8(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset after four bits of an operation.
    launch8(1'b0, 8'h33, 8'h44, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_result", 32'(result8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    void'(sb_q.pop_back());
    last_r = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    $display("reset mid-run: busy=%0d result=%02h done_seen=%0d", busy8, result8, seen);
    op8(1'b0, 8'h21, 8'h13, 1'b0, 1'b0, 1'b1);

    // Exhaustive WIDTH=4 sweep.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int ci = 0; ci < 2; ci++) begin
            start4 = 1'b1; sel4 = 1'(s); a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci);
            sb_q.push_back(model(4, 1'(s), a, b, 1'(ci)));
            @(posedge clk); @(negedge clk);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            edges = 0;
            for (int i = 1; i <= 10; i++) begin
              @(posedge clk); @(negedge clk);
              if (done4) begin
                edges = i;
                break;
              end
            end
            check("latency4", 32'(edges), 32'd4);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              check("result4", 32'(result4), 32'(e.r));
              check("cout4", 32'(cout4), 32'(e.c));
            end
            $display("op4 sel=%0d a=%0h b=%0h cin=%0d -> result=%0h cout=%0d", s, a, b, ci, result4, cout4);
          end
        end
      end
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
